dram_req_arbiter: RTL and testbench

- Upstream stage of the DRAM RAS/MUX/CAS sequencer.
- Accepts CPU access requests over a valid/ready handshake and generates periodic refresh requests internally.
- Arbitrates between CPU and refresh, then issues a single-cycle req pulse plus a latched address/command to the sequencer.
- Tracks each sequencer cycle with a fixed-length busy counter, so no new req is issued while a cycle is in flight.

---
 rtl/dram_req_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_dram_req_arbiter.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_req_arbiter.sv
// Front end of the DRAM RAS/MUX/CAS sequencer. It merges CPU requests with
// periodic refresh requests and starts one fixed-length sequencer access at a time.
module dram_req_arbiter #(
    parameter int ADDR_W         = 16,
    parameter int CYCLE_LEN      = 6,
    parameter int REFRESH_PERIOD = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_valid,
    output logic              cpu_ready,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_we,
    output logic              req,
    output logic [ADDR_W-1:0] req_addr,
    output logic              req_we,
    output logic              req_refresh,
    output logic              cpu_done,
    output logic              busy,
    output logic              refresh_overrun
);
    localparam int WAIT_W = $clog2(CYCLE_LEN);
    localparam int REF_W  = $clog2(REFRESH_PERIOD);
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(CYCLE_LEN - 2);
    localparam logic [REF_W-1:0]  REF_LAST  = REF_W'(REFRESH_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic [REF_W-1:0]  ref_cnt_r;
    logic [1:0]        refresh_pend_r;
    logic              hold_full_r;
    logic [ADDR_W-1:0] hold_addr_r;
    logic              hold_we_r;
    logic              last_refresh_r;
    logic              cur_cpu_r;
    logic              req_r;
    logic [ADDR_W-1:0] req_addr_r;
    logic              req_we_r;
    logic              req_refresh_r;
    logic              cpu_done_r;
    logic              busy_r;
    logic              overrun_r;
    logic              xfer_s;
    logic              tick_s;
    logic              grant_ref_s;
    logic              grant_cpu_s;
    logic              wait_end_s;

    assign xfer_s          = cpu_valid && !hold_full_r;
    assign tick_s          = (ref_cnt_r == REF_LAST);
    assign cpu_ready       = !hold_full_r;
    assign req             = req_r;
    assign req_addr        = req_addr_r;
    assign req_we          = req_we_r;
    assign req_refresh     = req_refresh_r;
    assign cpu_done        = cpu_done_r;
    assign busy            = busy_r;
    assign refresh_overrun = overrun_r;

    // Next-state decode with arbitration; refresh yields once after its own turn
    always_comb begin
        state_nxt_s = state_r;
        grant_ref_s = 1'b0;
        grant_cpu_s = 1'b0;
        wait_end_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if ((refresh_pend_r != 2'd0) && !(last_refresh_r && hold_full_r)) begin
                    grant_ref_s = 1'b1;
                    state_nxt_s = ISSUE;
                end else if (hold_full_r) begin
                    grant_cpu_s = 1'b1;
                    state_nxt_s = ISSUE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ISSUE: begin
                state_nxt_s = WAIT;
            end
            WAIT: begin
                if (wait_cnt_r == {WAIT_W{1'b0}}) begin
                    wait_end_s  = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM state, access window counter and arbitration history
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r        <= IDLE;
            wait_cnt_r     <= {WAIT_W{1'b0}};
            last_refresh_r <= 1'b0;
            cur_cpu_r      <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (state_r == ISSUE) begin
                wait_cnt_r <= WAIT_INIT;
            end else if ((state_r == WAIT) && (wait_cnt_r != {WAIT_W{1'b0}})) begin
                wait_cnt_r <= wait_cnt_r - WAIT_W'(1);
            end
            if (grant_ref_s || grant_cpu_s) begin
                last_refresh_r <= grant_ref_s;
                cur_cpu_r      <= grant_cpu_s;
            end
        end
    end

    // Refresh timer, saturating pending count and sticky overrun flag
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ref_cnt_r      <= {REF_W{1'b0}};
            refresh_pend_r <= 2'd0;
            overrun_r      <= 1'b0;
        end else begin
            ref_cnt_r <= tick_s ? {REF_W{1'b0}} : ref_cnt_r + REF_W'(1);
            if (tick_s && !grant_ref_s) begin
                if (refresh_pend_r != 2'd3) begin
                    refresh_pend_r <= refresh_pend_r + 2'd1;
                end
            end else if (!tick_s && grant_ref_s) begin
                refresh_pend_r <= refresh_pend_r - 2'd1;
            end
            if (tick_s && (refresh_pend_r == 2'd3)) begin
                overrun_r <= 1'b1;
            end
        end
    end

    // One-entry CPU holding register; freed when its access is launched
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hold_full_r <= 1'b0;
            hold_addr_r <= {ADDR_W{1'b0}};
            hold_we_r   <= 1'b0;
        end else if (xfer_s) begin
            hold_full_r <= 1'b1;
            hold_addr_r <= cpu_addr;
            hold_we_r   <= cpu_we;
        end else if (grant_cpu_s) begin
            hold_full_r <= 1'b0;
        end
    end

    // Registered sequencer outputs; address/command held until the next launch
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            req_r         <= 1'b0;
            req_addr_r    <= {ADDR_W{1'b0}};
            req_we_r      <= 1'b0;
            req_refresh_r <= 1'b0;
            cpu_done_r    <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            req_r      <= (state_nxt_s == ISSUE);
            busy_r     <= (state_nxt_s != IDLE);
            cpu_done_r <= wait_end_s && cur_cpu_r;
            if (grant_cpu_s) begin
                req_addr_r    <= hold_addr_r;
                req_we_r      <= hold_we_r;
                req_refresh_r <= 1'b0;
            end else if (grant_ref_s) begin
                req_addr_r    <= {ADDR_W{1'b0}};
                req_we_r      <= 1'b0;
                req_refresh_r <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dram_req_arbiter.sv
// Bench for dram_req_arbiter: three instances with refresh periods 1000, 16 and 2
// share one stimulus stream and are checked against a transaction-level model.
module tb_dram_req_arbiter;
    localparam int CL = 6;
    localparam int NI = 3;

    logic        clk;
    logic        reset_n;
    logic        cpu_valid;
    logic [15:0] cpu_addr;
    logic        cpu_we;
    logic        cpu_ready_w   [NI];
    logic        req_w         [NI];
    logic [15:0] req_addr_w    [NI];
    logic        req_we_w      [NI];
    logic        req_refresh_w [NI];
    logic        cpu_done_w    [NI];
    logic        busy_w        [NI];
    logic        ovr_w         [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int PER = (g == 0) ? 1000 : ((g == 1) ? 16 : 2);
        dram_req_arbiter #(.ADDR_W(16), .CYCLE_LEN(CL), .REFRESH_PERIOD(PER)) u_dut (
            .clk             (clk),
            .reset_n         (reset_n),
            .cpu_valid       (cpu_valid),
            .cpu_ready       (cpu_ready_w[g]),
            .cpu_addr        (cpu_addr),
            .cpu_we          (cpu_we),
            .req             (req_w[g]),
            .req_addr        (req_addr_w[g]),
            .req_we          (req_we_w[g]),
            .req_refresh     (req_refresh_w[g]),
            .cpu_done        (cpu_done_w[g]),
            .busy            (busy_w[g]),
            .refresh_overrun (ovr_w[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int edge_n = 0;
    int rel = 0;
    int ecnt = 0;

    // Reference model: one entry per instance, advanced once per clock edge.
    bit          m_hold    [NI];
    logic [15:0] m_hold_a  [NI];
    bit          m_hold_w  [NI];
    int          m_pend    [NI];
    bit          m_ovr     [NI];
    bit          m_last_ref[NI];
    int          m_left    [NI];  // clocks left in the running access, 0 = free
    bit          m_cur_cpu [NI];
    bit          m_done    [NI];
    logic [15:0] m_ra      [NI];
    bit          m_rw      [NI];
    bit          m_rr      [NI];

    function automatic int per(int i);
        case (i)
            0:       return 1000;
            1:       return 16;
            default: return 2;
        endcase
    endfunction

    function automatic logic [22:0] expv(int i);
        return {~m_hold[i], (m_left[i] == CL), m_ra[i], m_rw[i], m_rr[i],
                m_done[i], (m_left[i] != 0), m_ovr[i]};
    endfunction

    function automatic logic [22:0] obsv(int i);
        return {cpu_ready_w[i], req_w[i], req_addr_w[i], req_we_w[i], req_refresh_w[i],
                cpu_done_w[i], busy_w[i], ovr_w[i]};
    endfunction

    task automatic model_edge();
        if (!reset_n) begin
            ecnt = 0;
            for (int i = 0; i < NI; i++) begin
                m_hold[i] = 0; m_hold_a[i] = 16'h0000; m_hold_w[i] = 0;
                m_pend[i] = 0; m_ovr[i] = 0; m_last_ref[i] = 0; m_left[i] = 0;
                m_cur_cpu[i] = 0; m_done[i] = 0; m_ra[i] = 16'h0000; m_rw[i] = 0; m_rr[i] = 0;
            end
        end else begin
            ecnt++;
            for (int i = 0; i < NI; i++) begin
                bit xfer;
                bit tick;
                bit gref;
                xfer = cpu_valid && !m_hold[i];
                tick = (ecnt % per(i)) == 0;
                gref = 0;
                m_done[i] = 0;
                if (m_left[i] == 0) begin
                    if (m_pend[i] > 0 && !(m_last_ref[i] && m_hold[i])) begin
                        gref = 1; m_left[i] = CL; m_last_ref[i] = 1; m_cur_cpu[i] = 0;
                        m_ra[i] = 16'h0000; m_rw[i] = 0; m_rr[i] = 1;
                    end else if (m_hold[i]) begin
                        m_left[i] = CL; m_last_ref[i] = 0; m_cur_cpu[i] = 1;
                        m_ra[i] = m_hold_a[i]; m_rw[i] = m_hold_w[i]; m_rr[i] = 0; m_hold[i] = 0;
                    end
                end else begin
                    m_left[i]--;
                    if (m_left[i] == 0 && m_cur_cpu[i]) m_done[i] = 1;
                end
                if (xfer) begin
                    m_hold[i] = 1; m_hold_a[i] = cpu_addr; m_hold_w[i] = cpu_we;
                end
                if (tick && m_pend[i] == 3) m_ovr[i] = 1;
                if (tick && !gref) m_pend[i] = (m_pend[i] < 3) ? m_pend[i] + 1 : 3;
                else if (!tick && gref) m_pend[i]--;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        edge_n++;
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        cpu_valid = 1'b0;
        repeat (3) step();
        reset_n = 1'b1;
        rel = edge_n;
    endtask

    task automatic test_reset();
        cpu_addr = 16'h0000;
        cpu_we = 1'b0;
        do_reset();
        for (int i = 0; i < NI; i++) begin
            n_cmp++;
            if (obsv(i) !== {1'b1, 22'h000000}) begin
                n_bad++;
                $display("FAIL reset_state inst=%0d got=%h exp=%h", i, obsv(i), {1'b1, 22'h000000});
            end
        end
        step();
        for (int i = 0; i < NI; i++) begin
            n_cmp++;
            if (obsv(i) !== expv(i)) begin
                n_bad++;
                $display("FAIL reset_first_edge inst=%0d got=%h exp=%h", i, obsv(i), expv(i));
            end
        end
    endtask

    task automatic test_single_read();
        int k;
        int req_cyc;
        int done_cyc;
        int busy_cnt;
        logic [15:0] ra;
        logic rr;
        do_reset();
        req_cyc = -1; done_cyc = -1; busy_cnt = 0; ra = 16'h0000; rr = 1'b1;
        cpu_valid = 1'b1; cpu_addr = 16'h1234; cpu_we = 1'b0;
        step();
        k = edge_n;
        cpu_valid = 1'b0;
        for (int t = 0; t < 12; t++) begin
            step();
            for (int i = 0; i < NI; i++) begin
                n_cmp++;
                if (obsv(i) !== expv(i)) begin
                    n_bad++;
                    $display("FAIL single_read inst=%0d edge=%0d got=%h exp=%h", i, edge_n, obsv(i), expv(i));
                end
            end
            // The cycle following edge n is numbered n+1.
            if (req_w[0] && req_cyc < 0) begin
                req_cyc = edge_n + 1; ra = req_addr_w[0]; rr = req_refresh_w[0];
            end
            if (cpu_done_w[0] && done_cyc < 0) done_cyc = edge_n + 1;
            if (busy_w[0]) busy_cnt++;
        end
        n_cmp++;
        if (req_cyc !== k + 2) begin n_bad++; $display("FAIL read_req_cycle got=%0d exp=%0d", req_cyc, k + 2); end
        n_cmp++;
        if (ra !== 16'h1234) begin n_bad++; $display("FAIL read_req_addr got=%h exp=1234", ra); end
        n_cmp++;
        if (rr !== 1'b0) begin n_bad++; $display("FAIL read_req_refresh got=%b exp=0", rr); end
        n_cmp++;
        if (busy_cnt !== CL) begin n_bad++; $display("FAIL read_busy_len got=%0d exp=%0d", busy_cnt, CL); end
        n_cmp++;
        if (done_cyc !== k + 8) begin n_bad++; $display("FAIL read_done_cycle got=%0d exp=%0d", done_cyc, k + 8); end
    endtask

    task automatic test_pipelined_writes();
        int r1;
        int r2;
        bit sent;
        bit xfer_pre;
        logic [15:0] a2;
        logic w2;
        do_reset();
        r1 = -1; r2 = -1; sent = 0; a2 = 16'h0000; w2 = 1'b0;
        cpu_valid = 1'b1; cpu_addr = 16'hCAFE; cpu_we = 1'b1;
        step();
        cpu_valid = 1'b0;
        for (int t = 0; t < 30; t++) begin
            xfer_pre = cpu_valid && cpu_ready_w[0];
            step();
            for (int i = 0; i < NI; i++) begin
                n_cmp++;
                if (obsv(i) !== expv(i)) begin
                    n_bad++;
                    $display("FAIL pipelined inst=%0d edge=%0d got=%h exp=%h", i, edge_n, obsv(i), expv(i));
                end
            end
            if (xfer_pre && !sent) begin
                sent = 1;
                cpu_valid = 1'b0;
                n_cmp++;
                if (cpu_ready_w[0] !== 1'b0) begin
                    n_bad++;
                    $display("FAIL pipe_ready_drop got=%b exp=0", cpu_ready_w[0]);
                end
            end
            if (req_w[0]) begin
                if (r1 < 0) r1 = edge_n;
                else if (r2 < 0) begin r2 = edge_n; a2 = req_addr_w[0]; w2 = req_we_w[0]; end
            end
            if (r1 >= 0 && !sent && !cpu_valid && busy_w[0] && !req_w[0]) begin
                cpu_valid = 1'b1; cpu_addr = 16'hBEEF; cpu_we = 1'b1;
            end
        end
        n_cmp++;
        if (r2 - r1 !== CL + 1) begin n_bad++; $display("FAIL pipe_spacing got=%0d exp=%0d", r2 - r1, CL + 1); end
        n_cmp++;
        if (a2 !== 16'hBEEF) begin n_bad++; $display("FAIL pipe_addr got=%h exp=beef", a2); end
        n_cmp++;
        if (w2 !== 1'b1) begin n_bad++; $display("FAIL pipe_we got=%b exp=1", w2); end
    endtask

    task automatic test_refresh_only();
        int reqs[$];
        int dones;
        bit all_ref;
        do_reset();
        dones = 0; all_ref = 1;
        for (int t = 0; t < 70; t++) begin
            step();
            for (int i = 0; i < NI; i++) begin
                n_cmp++;
                if (obsv(i) !== expv(i)) begin
                    n_bad++;
                    $display("FAIL refresh_only inst=%0d edge=%0d got=%h exp=%h", i, edge_n, obsv(i), expv(i));
                end
            end
            if (req_w[1]) begin reqs.push_back(edge_n); if (!req_refresh_w[1]) all_ref = 0; end
            if (cpu_done_w[1]) dones++;
        end
        // Ticks land on edges rel+16, +32, +48, +64; each launches one edge later.
        n_cmp++;
        if (reqs.size() !== 4) begin n_bad++; $display("FAIL refresh_count got=%0d exp=4", reqs.size()); end
        for (int j = 0; j < reqs.size(); j++) begin
            n_cmp++;
            if (reqs[j] !== rel + 17 + 16 * j) begin
                n_bad++;
                $display("FAIL refresh_time idx=%0d got=%0d exp=%0d", j, reqs[j], rel + 17 + 16 * j);
            end
        end
        n_cmp++;
        if (!all_ref || dones != 0) begin
            n_bad++;
            $display("FAIL refresh_kind all_ref=%b dones=%0d exp all_ref=1 dones=0", all_ref, dones);
        end
    endtask

    task automatic test_contention();
        logic kinds[$];
        bit ovr_seen;
        bit ovr_drop;
        do_reset();
        ovr_seen = 0; ovr_drop = 0;
        cpu_valid = 1'b1;
        for (int t = 0; t < 70; t++) begin
            if (!cpu_ready_w[2]) begin cpu_addr = 16'($urandom); cpu_we = 1'($urandom); end
            step();
            for (int i = 0; i < NI; i++) begin
                n_cmp++;
                if (obsv(i) !== expv(i)) begin
                    n_bad++;
                    $display("FAIL contention inst=%0d edge=%0d got=%h exp=%h", i, edge_n, obsv(i), expv(i));
                end
            end
            if (req_w[2]) kinds.push_back(req_refresh_w[2]);
            if (ovr_w[2]) ovr_seen = 1;
            else if (ovr_seen) ovr_drop = 1;
        end
        // No tick precedes the first arbitration, so CPU goes first; then strict alternation.
        for (int j = 0; j < 7; j++) begin
            logic got;
            got = (j < kinds.size()) ? kinds[j] : 1'bx;
            n_cmp++;
            if (got !== 1'(j % 2)) begin
                n_bad++;
                $display("FAIL contention_order idx=%0d got=%b exp=%b", j, got, 1'(j % 2));
            end
        end
        n_cmp++;
        if (!ovr_seen || ovr_drop) begin
            n_bad++;
            $display("FAIL overrun_sticky seen=%b dropped=%b exp seen=1 dropped=0", ovr_seen, ovr_drop);
        end
    endtask

    task automatic test_mid_reset();
        int guard;
        guard = 0;
        while (!(busy_w[2] && !req_w[2]) && guard < 20) begin
            step();
            guard++;
        end
        n_cmp++;
        if (busy_w[2] !== 1'b1 || ovr_w[2] !== 1'b1) begin
            n_bad++;
            $display("FAIL midreset_pre busy=%b ovr=%b exp busy=1 ovr=1", busy_w[2], ovr_w[2]);
        end
        reset_n = 1'b0;
        step();
        for (int i = 0; i < NI; i++) begin
            n_cmp++;
            if ({busy_w[i], req_w[i], ovr_w[i], cpu_done_w[i]} !== 4'b0000) begin
                n_bad++;
                $display("FAIL midreset inst=%0d busy/req/ovr/done got=%b%b%b%b exp=0000",
                         i, busy_w[i], req_w[i], ovr_w[i], cpu_done_w[i]);
            end
        end
        reset_n = 1'b1;
        cpu_valid = 1'b0;
    endtask

    task automatic test_random();
        for (int t = 0; t < 1500; t++) begin
            reset_n = ($urandom_range(0, 299) != 0);
            cpu_valid = ($urandom_range(0, 99) < 60);
            cpu_addr = 16'($urandom);
            cpu_we = 1'($urandom);
            step();
            for (int i = 0; i < NI; i++) begin
                n_cmp++;
                if (obsv(i) !== expv(i)) begin
                    n_bad++;
                    $display("FAIL random inst=%0d edge=%0d got=%h exp=%h", i, edge_n, obsv(i), expv(i));
                end
            end
        end
        reset_n = 1'b1;
        cpu_valid = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        cpu_valid = 1'b0;
        cpu_addr = 16'h0000;
        cpu_we = 1'b0;
        test_reset();
        test_single_read();
        test_pipelined_writes();
        test_refresh_only();
        test_contention();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
